// File: rtl/airlock_pkg.sv
// airlock_pkg: state encoding, segment codes and helpers shared by the airlock sequencer files.
package airlock_pkg;

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      ANNOUNCE   = 4'd1,
      ARM_EVAC   = 4'd2,
      EVAC       = 4'd3,
      VACUUM     = 4'd4,
      OUTER_OPEN = 4'd5,
      ARM_PRESS  = 4'd6,
      PRESS      = 4'd7,
      FAULT      = 4'd8
   } stateT;

   // Active-low segments, bit order gfedcba
   localparam logic [6:0] L     = 7'b1000111;
   localparam logic [6:0] E     = 7'b0000110;
   localparam logic [6:0] P     = 7'b0001100;
   localparam logic [6:0] A     = 7'b0001000;
   localparam logic [6:0] F     = 7'b0001110;
   localparam logic [6:0] BLANK = 7'b1111111;

   function automatic logic isTimed(stateT s);
      return s == ANNOUNCE || s == EVAC || s == PRESS;
   endfunction

endpackage

// File: rtl/airlock_if.sv
// airlock_if: door/request/command inputs and display/status outputs of the airlock sequencer.
interface airlock_if #(
   parameter int CYC_W = 8
);
   logic             tick;
   logic             inner_port;
   logic             outer_port;
   logic             leave_req;
   logic             arrive_req;
   logic             evac;
   logic             pressurize;
   logic             fault_clr;
   logic             abort;
   logic [6:0]       display;
   logic             busy;
   logic             fault;
   logic             dir;
   logic [CYC_W-1:0] cycles;

   modport master (
      output tick, inner_port, outer_port, leave_req, arrive_req, evac, pressurize, fault_clr, abort,
      input  display, busy, fault, dir, cycles
   );

   modport slave (
      input  tick, inner_port, outer_port, leave_req, arrive_req, evac, pressurize, fault_clr, abort,
      output display, busy, fault, dir, cycles
   );
endinterface

// File: rtl/airlock_tick_timer.sv
// airlock_tick_timer: tick counter with clear, enable and a terminal count against a runtime limit.
module airlock_tick_timer #(
   parameter int TMR_W = 4
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [TMR_W-1:0] limit,
   output logic             done
);
   logic [TMR_W-1:0] count;

   always_ff @(posedge clock or negedge rst)
      if (!rst) count <= '0;
      else if (clear) count <= '0;
      else if (enable) count <= count + TMR_W'(1);

   // Fires on the tick that completes the limit-th count, so a phase lasts exactly limit ticks
   assign done = enable && count == limit - TMR_W'(1);
endmodule

// File: rtl/airlock_sequencer.sv
// airlock_sequencer: two-direction evacuate/pressurize airlock sequencer with interlock fault and cycle count.
// Define AIRLOCK_ABORT_EN to let abort cancel announce/arm and cut evacuation short.
module airlock_sequencer
   import airlock_pkg::*;
#(
   parameter int TMR_W          = 4,
   parameter int ANNOUNCE_TICKS = 1,
   parameter int EVAC_TICKS     = 2,
   parameter int PRESS_TICKS    = 4,
   parameter int CYC_W          = 8
) (
   input logic      clock,
   input logic      rst,
   airlock_if.slave bus
);
   stateT            state, nextState;
   logic             dirReg, dirNext;
   logic [CYC_W-1:0] cycleCount;
   logic [TMR_W-1:0] limit;
   logic             done, doorsShut, violation, countCycle;
   logic             abortIdle, abortPress, skipCount;

   assign doorsShut = !bus.inner_port && !bus.outer_port;
   assign violation = (bus.inner_port && bus.outer_port)
      || (bus.inner_port && (state == EVAC || state == VACUUM || state == OUTER_OPEN || state == PRESS))
      || (bus.outer_port && (state == ANNOUNCE || state == EVAC || state == PRESS));

   assign limit = state == ANNOUNCE ? TMR_W'(ANNOUNCE_TICKS)
                : state == EVAC     ? TMR_W'(EVAC_TICKS)
                :                     TMR_W'(PRESS_TICKS);

   airlock_tick_timer #(.TMR_W(TMR_W)) timer (
      .clock  (clock),
      .rst    (rst),
      .clear  (nextState != state && isTimed(nextState)),
      .enable (bus.tick && isTimed(state)),
      .limit  (limit),
      .done   (done)
   );

`ifdef AIRLOCK_ABORT_EN
   logic skipNext;
   assign abortIdle  = bus.abort && (state == ANNOUNCE || state == ARM_EVAC);
   assign abortPress = bus.abort && state == EVAC;
   // An aborted evacuation still repressurizes, but that pass is not a completed cycle
   assign skipNext   = nextState == PRESS && (state == PRESS ? skipCount : abortPress);
   always_ff @(posedge clock or negedge rst)
      if (!rst) skipCount <= 1'b0;
      else skipCount <= skipNext;
`else
   logic unusedAbort;
   assign abortIdle   = 1'b0;
   assign abortPress  = 1'b0;
   assign skipCount   = 1'b0;
   assign unusedAbort = bus.abort;
`endif

   always_ff @(posedge clock or negedge rst)
      if (!rst) begin
         state      <= IDLE;
         dirReg     <= 1'b0;
         cycleCount <= '0;
      end else begin
         state      <= nextState;
         dirReg     <= dirNext;
         cycleCount <= cycleCount + CYC_W'(countCycle);
      end

   always_comb begin
      nextState = state;
      dirNext   = dirReg;
      case (state)
         IDLE:
            if (doorsShut && bus.leave_req != bus.arrive_req) begin
               nextState = ANNOUNCE;
               dirNext   = bus.arrive_req;
            end
         ANNOUNCE:   if (done) nextState = ARM_EVAC;
         ARM_EVAC:   if (bus.evac && doorsShut) nextState = EVAC;
         EVAC:       if (done) nextState = VACUUM;
         VACUUM:     if (bus.outer_port && !bus.inner_port) nextState = OUTER_OPEN;
         OUTER_OPEN: if (doorsShut && (dirReg || !bus.leave_req)) nextState = ARM_PRESS;
         ARM_PRESS:  if (bus.pressurize && doorsShut) nextState = PRESS;
         PRESS:      if (done) nextState = IDLE;
         FAULT:      if (bus.fault_clr && doorsShut) nextState = ARM_PRESS;
         default:    nextState = IDLE;
      endcase
      if (abortIdle) nextState = IDLE;
      if (abortPress) nextState = PRESS;
      if (violation) nextState = FAULT;
   end

   assign countCycle = state == PRESS && nextState == IDLE && !skipCount;

   assign bus.display = state == ANNOUNCE ? (dirReg ? A : L)
                      : state == EVAC     ? E
                      : state == PRESS    ? P
                      : state == FAULT    ? F
                      :                     BLANK;
   assign bus.busy    = state != IDLE;
   assign bus.fault   = state == FAULT;
   assign bus.dir     = dirReg;
   assign bus.cycles  = cycleCount;
endmodule

// File: doc/airlock_sequencer.md
Name: airlock_sequencer

Overview:
- Parametrised successor to the single-direction airlock interlock FSM.
- Sequences a full evacuate/pressurize cycle for both leaving and arriving crew.
- Owns its duration timer; the external counter is gone. Detects door-interlock violations and counts completed cycles.
- Sits between the switch/debounce front end and the 7-segment driver; `tick` comes from the shared clock divider.

Parameters:
- TMR_W, 4, width of internal tick timer.
- ANNOUNCE_TICKS, 1, ticks the direction letter is shown after a request.
- EVAC_TICKS, 2, ticks to evacuate chamber.
- PRESS_TICKS, 4, ticks to pressurize chamber.
- CYC_W, 8, width of completed-cycle counter.

Ports:
- clock  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle timing strobe
- inner_port  in  1  inner door open (1=open)
- outer_port  in  1  outer door open (1=open)
- leave_req  in  1  crew leaving request (level)
- arrive_req  in  1  crew arriving request (level)
- evac  in  1  evacuate command
- pressurize  in  1  pressurize command
- fault_clr  in  1  clears FAULT
- abort  in  1  abort evacuation (used only with macro)
- display  out  7  active-low segments gfedcba
- busy  out  1  1 in any state except IDLE
- fault  out  1  1 in FAULT
- dir  out  1  0=leaving, 1=arriving; latched at request
- cycles  out  CYC_W  completed cycles, wraps modulo 2^CYC_W

Behaviour:
- Reset (rst=0, async): state IDLE, timer 0, dir 0, cycles 0. Outputs: display blank, busy 0, fault 0.
- All transitions on posedge clock. Outputs decode from state and dir (Moore), so they show the new state 1 cycle after the triggering input.
- Timer clears on entry to ANNOUNCE, EVAC and PRESS. It increments on each `tick` while in those states. A state exits in the cycle its timer equals N-1 with `tick`=1, so it lasts exactly N ticks.
- IDLE: leave_req & ~arrive_req & both doors closed -> ANNOUNCE, dir=0. arrive_req & ~leave_req & doors closed -> ANNOUNCE, dir=1. Both requests together -> stay IDLE.
- ANNOUNCE: display L (dir 0) or A (dir 1); after ANNOUNCE_TICKS -> ARM_EVAC.
- ARM_EVAC: blank; evac & doors closed -> EVAC.
- EVAC: display E; after EVAC_TICKS -> VACUUM.
- VACUUM: blank; outer_port & ~inner_port -> OUTER_OPEN.
- OUTER_OPEN: blank; ~outer_port & ~inner_port -> ARM_PRESS.
  - dir 0: also requires ~leave_req.
  - dir 1: no extra condition.
- ARM_PRESS: blank; pressurize & doors closed -> PRESS.
- PRESS: display P; after PRESS_TICKS -> IDLE, cycles+1.
- Interlock violation -> FAULT, which has priority over every other transition:
  - inner_port=1 in EVAC, VACUUM, OUTER_OPEN or PRESS;
  - outer_port=1 in ANNOUNCE, EVAC or PRESS;
  - both doors open in any state.
- FAULT: display F, fault=1, busy=1. fault_clr & both doors closed -> ARM_PRESS, so the chamber is always repressurized after a fault.
- Segment codes:
  - L=1000111
  - E=0000110
  - P=0001100
  - A=0001000
  - F=0001110
  - blank=1111111
- Unused state encodings go to IDLE on the next clock.
- Mid-operation reset returns to IDLE immediately and clears cycles.

Optional Feature:
- AIRLOCK_ABORT_EN defined: abort=1 in ANNOUNCE or ARM_EVAC -> IDLE, no count. abort=1 in EVAC -> PRESS with timer cleared; cycles is not incremented on that PRESS exit. FAULT still takes priority over abort.
- Not defined: abort port is present but ignored; no abort logic is synthesised.

Decomposition:
- Package airlock_pkg holds:
  - state enum (IDLE, ANNOUNCE, ARM_EVAC, EVAC, VACUUM, OUTER_OPEN, ARM_PRESS, PRESS, FAULT; 4-bit);
  - 7-bit segment constants L, E, P, A, F, BLANK.
- One sub-module, airlock_tick_timer: clear/enable/terminal-count with a runtime limit input. It is shared across ANNOUNCE, EVAC and PRESS.

Test Plan:
- Leave cycle, defaults: leave_req=1 -> display L for 1 tick. evac -> E for 2 ticks. Open then close outer, drop leave_req, pressurize -> P for 4 ticks -> IDLE, cycles=1.
- Arrive cycle: arrive_req=1 -> display 0001000, dir=1; full sequence completes with arrive_req still high -> cycles=2.
- Interlock: inner_port=1 during EVAC -> next clock fault=1, display 0001110. fault_clr with doors open -> stays FAULT. Close doors, fault_clr -> ARM_PRESS; pressurize -> P.
- Simultaneous leave_req & arrive_req in IDLE -> remains IDLE, busy=0. Request with outer_port=1 -> remains IDLE.
- rst low mid-PRESS between clock edges -> display blank, cycles=0 immediately, before the next clock edge. Wrap check: CYC_W=2, five cycles -> cycles=1.
- AIRLOCK_ABORT_EN: abort in EVAC -> PRESS next cycle, after 4 ticks IDLE with cycles unchanged. Without macro the same stimulus stays in EVAC and completes normally.
